register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised register file for the datapath: 2 combinational read ports, 1 synchronous write port,
//  optional hardwired zero register, hardware clear sequencer, registered debug tap.
//  Generalises the fixed 32x32 register file with its fixed REG14 tap to any width and depth.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; depth NREGS = 2**AW
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary storage
// PORTS
//  clk                 in   1   rising-edge clock
//  reset               in   1   asynchronous, active-high reset
//  Reg_Write_i         in   1   write enable
//  Write_Register_i    in   AW  write address
//  Write_Data_i        in   DW  write data
//  Read_Register_1_i   in   AW  read port 1 address
//  Read_Register_2_i   in   AW  read port 2 address
//  Read_Data_1_o       out  DW  read port 1 data, combinational
//  Read_Data_2_o       out  DW  read port 2 data, combinational
//  clr_i               in   1   single-cycle request to start the clear sweep
//  busy_o              out  1   clear sweep in progress
//  wr_drop_o           out  1   registered 1-cycle pulse: a write was discarded because busy_o was high
//  dbg_sel_i           in   AW  debug tap register select
//  dbg_data_o          out  DW  debug tap data, registered
// BEHAVIOUR
//  Reset, asynchronous:
//   - all NREGS entries = 0
//   - FSM = IDLE, sweep counter = 0
//   - busy_o = 0, wr_drop_o = 0, dbg_data_o = 0
//  Write:
//   - in IDLE, Reg_Write_i=1 at a rising edge stores Write_Data_i at Write_Register_i
//   - if ZERO_REG=1 and address is 0, the write is silently ignored; wr_drop_o stays 0
//  Read:
//   - Read_Data_n_o = mem[Read_Register_n_i], purely combinational
//   - address 0 returns 0 when ZERO_REG=1
//   - both ports may read the same address
//  FSM states IDLE and CLEAR:
//   - IDLE -> CLEAR on clr_i=1 at an edge; counter loads 0; busy_o=1 from the next cycle
//   - CLEAR: each edge writes 0 to mem[counter], then counter increments
//   - CLEAR -> IDLE at the edge that clears entry NREGS-1; counter wraps to 0; busy_o=0 the next cycle
//   - the sweep spans exactly NREGS cycles with busy_o=1
//  During CLEAR:
//   - clr_i is ignored
//   - any Reg_Write_i=1 is discarded and raises wr_drop_o for 1 cycle
//   - reads return current array contents; entries not yet swept keep their old values
//  clr_i and Reg_Write_i together in IDLE: the write is discarded and counted as a drop; the clear wins.
//  Debug tap: dbg_data_o <= read value of mem[dbg_sel_i] each edge (1-cycle latency, same ZERO_REG rule).
//  Reset asserted mid-sweep aborts the sweep immediately; all state returns to reset values.
// CONFIGURATION
//  Macro REGFILE_BYPASS_EN
//   Defined:
//    - if Reg_Write_i=1, the write would be accepted this cycle, and Write_Register_i == Read_Register_n_i,
//      then Read_Data_n_o = Write_Data_i in the same cycle (write-to-read forwarding)
//    - no forwarding for address 0 when ZERO_REG=1
//    - the debug tap is not bypassed
//   Undefined:
//    - reads return the pre-write value until the edge completes
// TESTING
//  1. Reset, then read all addresses on both ports -> every read returns 32'h0; busy_o=0; dbg_data_o=0.
//  2. Write 32'hFEDCAB98 to reg 14, then read ports 1/2 = 14 -> both return 32'hFEDCAB98 after the edge;
//     dbg_sel_i=14 -> dbg_data_o = 32'hFEDCAB98 one cycle later.
//  3. ZERO_REG=1: write 32'h89ABCDEF to reg 0 -> reads of reg 0 return 0; wr_drop_o stays 0.
//  4. Same-cycle write 32'h12345678 to reg 5 with read port 1 = 5 -> REGFILE_BYPASS_EN: 32'h12345678
//     in that cycle; without it: old value, then 32'h12345678 after the edge.
//  5. Fill regs 1..31 with their index, pulse clr_i -> busy_o high for exactly 32 cycles; write to reg 3
//     mid-sweep -> wr_drop_o pulse and no effect; all regs read 0 afterwards.
//  6. Assert reset at sweep cycle 10 -> busy_o=0 immediately; all regs 0; a new write to reg 7 then succeeds.

Source files
------------

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file: 2 combinational reads, 1 synchronous write, clear sweep, debug tap.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Reg_Write_i,
  input  logic [AW-1:0] Write_Register_i,
  input  logic [DW-1:0] Write_Data_i,
  input  logic [AW-1:0] Read_Register_1_i,
  input  logic [AW-1:0] Read_Register_2_i,
  output logic [DW-1:0] Read_Data_1_o,
  output logic [DW-1:0] Read_Data_2_o,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          wr_drop_o,
  input  logic [AW-1:0] dbg_sel_i,
  output logic [DW-1:0] dbg_data_o
);

  localparam int            NREGS = 2 ** AW;
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE   = AW'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_drop_q, wr_drop_d;
  logic [DW-1:0] dbg_q, dbg_d;
  logic [DW-1:0] mem_q [NREGS];

  logic          wr_acc_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [DW-1:0] mem_wdata_s;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    if (is_zero_reg(a)) return '0;
    else                return mem_q[a];
  endfunction

  // Next-state, sweep/write port selection and drop detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_drop_d   = 1'b0;
    wr_acc_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = Write_Register_i;
    mem_wdata_s = Write_Data_i;
    dbg_d       = rd_val(dbg_sel_i);
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          // A clear request outranks a simultaneous write
          state_d   = CLEAR;
          cnt_d     = '0;
          wr_drop_d = Reg_Write_i;
        end else if (Reg_Write_i && !is_zero_reg(Write_Register_i)) begin
          wr_acc_s = 1'b1;
          mem_we_s = 1'b1;
        end else begin
          wr_acc_s = 1'b0;
        end
      end
      CLEAR: begin
        wr_drop_d   = Reg_Write_i;
        mem_we_s    = 1'b1;
        mem_waddr_s = cnt_q;
        mem_wdata_s = '0;
        cnt_d       = cnt_q + ONE;
        if (cnt_q == LAST) state_d = IDLE;
        else               state_d = CLEAR;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and debug registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
      dbg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
      dbg_q     <= dbg_d;
    end
  end

  // Storage array, shared by the write port and the clear sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign Read_Data_1_o = (wr_acc_s && (Write_Register_i == Read_Register_1_i)) ? Write_Data_i
                                                                              : rd_val(Read_Register_1_i);
  assign Read_Data_2_o = (wr_acc_s && (Write_Register_i == Read_Register_2_i)) ? Write_Data_i
                                                                              : rd_val(Read_Register_2_i);
`else
  assign Read_Data_1_o = rd_val(Read_Register_1_i);
  assign Read_Data_2_o = rd_val(Read_Register_2_i);
`endif

  assign busy_o     = (state_q == CLEAR);
  assign wr_drop_o  = wr_drop_q;
  assign dbg_data_o = dbg_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (DW=32, AW=5, ZERO_REG=1) against a behavioural model.
module tb_register_file_mp;

  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        Reg_Write_i;
  logic [4:0]  Write_Register_i;
  logic [31:0] Write_Data_i;
  logic [4:0]  Read_Register_1_i;
  logic [4:0]  Read_Register_2_i;
  logic [31:0] Read_Data_1_o;
  logic [31:0] Read_Data_2_o;
  logic        clr_i;
  logic        busy_o;
  logic        wr_drop_o;
  logic [4:0]  dbg_sel_i;
  logic [31:0] dbg_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  register_file_mp #(.DW(32), .AW(5), .ZERO_REG(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (Reg_Write_i),
    .Write_Register_i  (Write_Register_i),
    .Write_Data_i      (Write_Data_i),
    .Read_Register_1_i (Read_Register_1_i),
    .Read_Register_2_i (Read_Register_2_i),
    .Read_Data_1_o     (Read_Data_1_o),
    .Read_Data_2_o     (Read_Data_2_o),
    .clr_i             (clr_i),
    .busy_o            (busy_o),
    .wr_drop_o         (wr_drop_o),
    .dbg_sel_i         (dbg_sel_i),
    .dbg_data_o        (dbg_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: plain array, a sweep position counted 0..NREGS, and sampled outputs.
  logic [31:0] m_mem [NREGS];
  bit          m_busy;
  int          m_pos;
  bit          m_drop;
  logic [31:0] m_dbg;

  function automatic logic [31:0] m_stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : m_mem[a];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (!m_busy && !clr_i && Reg_Write_i && (Write_Register_i == a) && (a != 5'd0))
      return Write_Data_i;
`endif
    return m_stored(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] = 32'h0;
      m_busy = 1'b0;
      m_pos  = 0;
      m_drop = 1'b0;
      m_dbg  = 32'h0;
    end else begin
      m_dbg  = m_stored(dbg_sel_i);
      m_drop = Reg_Write_i && (m_busy || clr_i);
      if (m_busy) begin
        m_mem[m_pos] = 32'h0;
        m_pos = m_pos + 1;
        if (m_pos == NREGS) begin
          m_busy = 1'b0;
          m_pos  = 0;
        end
      end else if (clr_i) begin
        m_busy = 1'b1;
        m_pos  = 0;
      end else if (Reg_Write_i && Write_Register_i != 5'd0) begin
        m_mem[Write_Register_i] = Write_Data_i;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #1;
    check("rd1_model",  Read_Data_1_o, m_read(Read_Register_1_i));
    check("rd2_model",  Read_Data_2_o, m_read(Read_Register_2_i));
    check("busy_model", {31'h0, busy_o}, {31'h0, m_busy});
    check("drop_model", {31'h0, wr_drop_o}, {31'h0, m_drop});
    check("dbg_model",  dbg_data_o, m_dbg);
  end

  task automatic idle_inputs();
    Reg_Write_i = 1'b0; Write_Register_i = 5'd0; Write_Data_i = 32'h0;
    clr_i = 1'b0;
  endtask

  task automatic fill_index();
    for (int a = 1; a < NREGS; a++) begin
      @(negedge clk);
      Reg_Write_i = 1'b1; Write_Register_i = 5'(a); Write_Data_i = 32'(a);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  int busy_cnt;

  initial begin
    reset = 1'b1;
    idle_inputs();
    Read_Register_1_i = 5'd0; Read_Register_2_i = 5'd0; dbg_sel_i = 5'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state on all addresses
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      Read_Register_1_i = 5'(a); Read_Register_2_i = 5'(31 - a); dbg_sel_i = 5'(a);
      #2;
      check("reset_rd1", Read_Data_1_o, 32'h0);
      check("reset_rd2", Read_Data_2_o, 32'h0);
    end
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_dbg", dbg_data_o, 32'h0);

    // Write reg 14, read both ports, debug tap one cycle later
    @(negedge clk);
    Reg_Write_i = 1'b1; Write_Register_i = 5'd14; Write_Data_i = 32'hFEDCAB98;
    @(negedge clk);
    idle_inputs();
    Read_Register_1_i = 5'd14; Read_Register_2_i = 5'd14; dbg_sel_i = 5'd14;
    #2;
    check("r14_rd1", Read_Data_1_o, 32'hFEDCAB98);
    check("r14_rd2", Read_Data_2_o, 32'hFEDCAB98);
    @(negedge clk);
    #2;
    check("r14_dbg", dbg_data_o, 32'hFEDCAB98);

    // Zero register ignores writes without a drop
    @(negedge clk);
    Reg_Write_i = 1'b1; Write_Register_i = 5'd0; Write_Data_i = 32'h89ABCDEF;
    Read_Register_1_i = 5'd0; dbg_sel_i = 5'd0;
    @(negedge clk);
    idle_inputs();
    #2;
    check("r0_rd1", Read_Data_1_o, 32'h0);
    check("r0_drop", {31'h0, wr_drop_o}, 32'h0);
    @(negedge clk);
    #2;
    check("r0_dbg", dbg_data_o, 32'h0);

    // Same-cycle write and read of reg 5
    @(negedge clk);
    Reg_Write_i = 1'b1; Write_Register_i = 5'd5; Write_Data_i = 32'h12345678;
    Read_Register_1_i = 5'd5;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("r5_same_cycle", Read_Data_1_o, 32'h12345678);
`else
    check("r5_same_cycle", Read_Data_1_o, 32'h0);
`endif
    @(negedge clk);
    idle_inputs();
    #2;
    check("r5_after_edge", Read_Data_1_o, 32'h12345678);

    // Full clear sweep with a write attempt mid-sweep
    fill_index();
    Read_Register_1_i = 5'd31;
    #2;
    check("fill_r31", Read_Data_1_o, 32'd31);
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      Reg_Write_i = (c == 5); Write_Register_i = 5'd3; Write_Data_i = 32'hDEADBEEF;
      #2;
      if (c == 6) check("sweep_drop", {31'h0, wr_drop_o}, 32'h1);
      if (!busy_o) break;
      busy_cnt++;
      @(negedge clk);
    end
    idle_inputs();
    check("sweep_len", busy_cnt, 32);
    for (int a = 0; a < NREGS; a++) begin
      @(negedge clk);
      Read_Register_1_i = 5'(a); Read_Register_2_i = 5'(a);
      #2;
      check("swept_rd1", Read_Data_1_o, 32'h0);
    end

    // Reset in the middle of a sweep
    fill_index();
    Read_Register_1_i = 5'd20;
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy_o}, 32'h0);
    check("abort_r20", Read_Data_1_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    Reg_Write_i = 1'b1; Write_Register_i = 5'd7; Write_Data_i = 32'h0BADCAFE;
    @(negedge clk);
    idle_inputs();
    Read_Register_2_i = 5'd7;
    #2;
    check("post_reset_r7", Read_Data_2_o, 32'h0BADCAFE);

    // Randomised traffic, checked cycle by cycle against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      Reg_Write_i      = 1'($urandom_range(0, 1));
      Write_Register_i = 5'($urandom_range(0, 31));
      Write_Data_i     = $urandom;
      clr_i            = ($urandom_range(0, 59) == 0);
      Read_Register_1_i = ($urandom_range(0, 2) == 0) ? Write_Register_i : 5'($urandom_range(0, 31));
      Read_Register_2_i = ($urandom_range(0, 2) == 0) ? Write_Register_i : 5'($urandom_range(0, 31));
      dbg_sel_i        = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
